psc_stream_array: RTL and testbench
===================================

PSC_STREAM_ARRAY -- requirements
Module: psc_stream_array

Interface
REQ-001 SHALL have parameter MAX_WORD_LENGTH, default 16, giving the maximum word width in bits (multiple of 8, 8..64).
REQ-002 SHALL have parameter ARRAY_DIM, default 2, giving the tile count.
REQ-003 SHALL have parameter TILE_DIM, default 2, giving lanes per tile; total lanes L = ARRAY_DIM*TILE_DIM.
REQ-004 SHALL have parameter WORDS_PER_LANE, default 4, giving the number of words held per lane.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port mode, input, 2 bits: 00 idle, 01 P2S, 10 S2P, 11 reserved.
REQ-008 SHALL have port word_len, input, 4 bits: active word length in bytes.
REQ-009 SHALL have port start, input, 1 bit: transfer request.
REQ-010 SHALL have port busy, output, 1 bit: transfer in progress.
REQ-011 SHALL have port finish, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have port serial_data_in, input, 8*L bits: one byte per lane.
REQ-013 SHALL have port s_in_valid, input, 1 bit: serial_data_in is valid for all lanes.
REQ-014 SHALL have port s_in_ready, output, 1 bit: the block accepts serial input.
REQ-015 SHALL have port serial_data_out, output, 8*L bits: one byte per lane.
REQ-016 SHALL have port s_out_valid, output, 1 bit: serial_data_out is valid.
REQ-017 SHALL have port s_out_ready, input, 1 bit: the consumer accepts serial output.
REQ-018 SHALL have port parallel_data_in, input, WORDS_PER_LANE*MAX_WORD_LENGTH*L bits.
REQ-019 SHALL have port parallel_data_out, output, WORDS_PER_LANE*MAX_WORD_LENGTH*L bits.

Function
REQ-020 SHALL run all lanes in lockstep from one FSM with states IDLE, RUN and DONE.
REQ-021 SHALL, in IDLE, accept start only when mode is 01 or 10; it SHALL latch mode and the effective word length WLe and go to RUN on the next edge.
REQ-022 SHALL compute WLe = word_len, except that 0 or values above MAX_WORD_LENGTH/8 clamp to MAX_WORD_LENGTH/8.
REQ-023 SHALL, for P2S, load parallel_data_in into the lane registers on the accepting edge.
REQ-024 SHALL set beat count N = WORDS_PER_LANE*WLe.
REQ-025 SHALL serialise in this byte order: word 0 byte 0 (LSB) first, through word WORDS_PER_LANE-1 byte WLe-1.
REQ-026 SHALL, in P2S RUN, hold s_out_valid=1 with the current byte stable until s_out_valid&&s_out_ready, then advance the beat counter.
REQ-027 SHALL, in S2P RUN, hold s_in_ready=1 and capture one byte per lane on each s_in_valid cycle; s_in_valid outside RUN is ignored.
REQ-028 SHALL zero-fill the S2P bytes at or above WLe in each word.
REQ-029 SHALL, when the Nth beat completes, go to DONE; DONE lasts exactly one cycle with finish=1, then returns to IDLE.
REQ-030 SHALL hold busy=1 in RUN and DONE, and ignore start, mode and word_len changes in those states.
REQ-031 SHALL update parallel_data_out, in S2P, on the DONE edge only, and hold it otherwise; P2S never changes it.
REQ-032 SHALL keep serial_data_out=0 whenever s_out_valid=0.
REQ-033 SHALL treat mode 00 or 11 with start as a no-op: it stays in IDLE with no finish.

Reset
REQ-034 SHALL, on reset low at any time including mid-transfer, immediately enter IDLE and clear beat count and lane registers.
REQ-035 SHALL drive all outputs to 0 during reset (busy, finish, s_in_ready, s_out_valid, serial_data_out, parallel_data_out).
REQ-036 SHALL produce no finish for an aborted transfer.

Configuration
REQ-037 SHALL, with macro PSC_STREAM_ARRAY_STATS_EN defined, add output xfer_count[15:0], which is reset to 0, increments on every finish and saturates at 16'hFFFF.
REQ-038 SHALL, without PSC_STREAM_ARRAY_STATS_EN, have no such port or counter, with all other behaviour identical.

Structure
REQ-039 SHALL place the mode encodings, the FSM state type and the byte-width constant in shared package psc_pkg.
REQ-040 SHALL implement one lane's shift/capture datapath as sub-module psc_lane, instantiated L times, with control taken from the single top-level FSM.

Verification
REQ-041 SHALL cover P2S with L=4, MAX=16, WPL=4, word_len=2 and s_out_ready always 1: 8 beats on cycles t+1..t+8, finish at t+9, and lane 0 bytes matching parallel_data_in LSB-first.
REQ-042 SHALL cover the same P2S with s_out_ready toggling 1,0: the byte is held stable while stalled, 8 accepted beats occur, and finish follows the 8th accept by one cycle.
REQ-043 SHALL cover S2P with word_len=1 and 4 valid beats of 0xA1..0xA4: each lane's words equal 0x00A1..0x00A4, and parallel_data_out changes only at DONE.
REQ-044 SHALL cover word_len=0 and word_len=9 with MAX=16: both clamp to 2 and give 8 beats; start with mode=11 gives no busy and no finish.
REQ-045 SHALL cover reset low after beat 3 of a P2S transfer: outputs are 0 at once, there is no finish, and the next start runs the full 8 beats.
REQ-046 SHALL cover, with PSC_STREAM_ARRAY_STATS_EN defined, 3 complete transfers plus 1 aborted transfer: xfer_count=3.

Source files
------------

// File: rtl/psc_pkg.sv
// Shared definitions for the psc_stream_array block: byte width, transfer
// mode encodings, the control FSM state type and an index-width helper.
package psc_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_P2S  = 2'b01,
        MODE_S2P  = 2'b10,
        MODE_RSVD = 2'b11
    } psc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } psc_state_e;

    // Width of an index that addresses n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psc_lane.sv
// One lane of the stream array: a WORDS_PER_LANE x MAX_WORD_LENGTH register
// that is parallel-loaded and read out byte by byte (P2S), or filled byte by
// byte and committed to a parallel output register (S2P). All sequencing
// comes from the top-level FSM through word_idx/byte_idx and the strobes.
module psc_lane
    import psc_pkg::*;
#(
    parameter int MAX_WORD_LENGTH = 16,
    parameter int WORDS_PER_LANE  = 4,
    parameter int WIDX_W          = idx_width(WORDS_PER_LANE),
    parameter int BIDX_W          = idx_width(MAX_WORD_LENGTH / BYTE_W)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      load,
    input  logic                                      clear,
    input  logic                                      capture,
    input  logic                                      commit,
    input  logic                                      ser_en,
    input  logic [WIDX_W-1:0]                         word_idx,
    input  logic [BIDX_W-1:0]                         byte_idx,
    input  logic [WORDS_PER_LANE*MAX_WORD_LENGTH-1:0] par_in,
    input  logic [BYTE_W-1:0]                         ser_in,
    output logic [BYTE_W-1:0]                         ser_out,
    output logic [WORDS_PER_LANE*MAX_WORD_LENGTH-1:0] par_out
);

    localparam int BPW    = MAX_WORD_LENGTH / BYTE_W;
    localparam int LANE_W = WORDS_PER_LANE * MAX_WORD_LENGTH;

    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] lane_d;
    logic [LANE_W-1:0] par_q;

    // Next lane contents: parallel load, clear before a capture run, or one byte written in place.
    always_comb begin
        // NOTE: lane_d gets a default before any branch so no path leaves it unassigned (no latch).
        lane_d = lane_q;
        if (load) begin
            lane_d = par_in;
        end else if (clear) begin
            lane_d = '0;
        end else if (capture) begin
            for (int w = 0; w < WORDS_PER_LANE; w++) begin
                for (int b = 0; b < BPW; b++) begin
                    if (word_idx == WIDX_W'(w) && byte_idx == BIDX_W'(b)) begin
                        lane_d[w*MAX_WORD_LENGTH + b*BYTE_W +: BYTE_W] = ser_in;
                    end
                end
            end
        end
    end

    // Byte offered on the serial output; forced to zero whenever it is not valid.
    always_comb begin
        ser_out = '0;
        if (ser_en) begin
            for (int w = 0; w < WORDS_PER_LANE; w++) begin
                for (int b = 0; b < BPW; b++) begin
                    if (word_idx == WIDX_W'(w) && byte_idx == BIDX_W'(b)) begin
                        ser_out = lane_q[w*MAX_WORD_LENGTH + b*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // Lane register and committed parallel output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the lane store is a flop vector, not RAM, so it can and must be cleared on reset; an aborted transfer leaves no data behind.
            lane_q <= '0;
            par_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            lane_q <= lane_d;
            if (commit) begin
                par_q <= lane_d;
            end
        end
    end

    assign par_out = par_q;

endmodule

// File: rtl/psc_stream_array.sv
// Lockstep parallel<->serial stream array. One IDLE/RUN/DONE FSM sequences
// ARRAY_DIM*TILE_DIM psc_lane instances, one byte per lane per beat.
// Optional feature: define PSC_STREAM_ARRAY_STATS_EN to add xfer_count, a
// saturating count of completed transfers.
module psc_stream_array
    import psc_pkg::*;
#(
    parameter int MAX_WORD_LENGTH = 16,
    parameter int ARRAY_DIM       = 2,
    parameter int TILE_DIM        = 2,
    parameter int WORDS_PER_LANE  = 4
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic [1:0]                                                  mode,
    input  logic [3:0]                                                  word_len,
    input  logic                                                        start,
    output logic                                                        busy,
    output logic                                                        finish,
    input  logic [BYTE_W*ARRAY_DIM*TILE_DIM-1:0]                        serial_data_in,
    input  logic                                                        s_in_valid,
    output logic                                                        s_in_ready,
    output logic [BYTE_W*ARRAY_DIM*TILE_DIM-1:0]                        serial_data_out,
    output logic                                                        s_out_valid,
    input  logic                                                        s_out_ready,
    input  logic [WORDS_PER_LANE*MAX_WORD_LENGTH*ARRAY_DIM*TILE_DIM-1:0] parallel_data_in,
    output logic [WORDS_PER_LANE*MAX_WORD_LENGTH*ARRAY_DIM*TILE_DIM-1:0] parallel_data_out
`ifdef PSC_STREAM_ARRAY_STATS_EN
    ,
    output logic [15:0]                                                 xfer_count
`endif
);

    localparam int L      = ARRAY_DIM * TILE_DIM;
    localparam int BPW    = MAX_WORD_LENGTH / BYTE_W;
    localparam int LANE_W = WORDS_PER_LANE * MAX_WORD_LENGTH;
    localparam int WIDX_W = idx_width(WORDS_PER_LANE);
    localparam int BIDX_W = idx_width(BPW);
    localparam int BEAT_W = idx_width(WORDS_PER_LANE * BPW);
    localparam logic [3:0] BPW4 = 4'(BPW);

    psc_state_e        state_q;
    psc_mode_e         mode_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_last_q;
    logic [WIDX_W-1:0] word_q;
    logic [BIDX_W-1:0] byte_q;
    logic [BIDX_W-1:0] byte_last_q;

    logic [3:0] wle_d;
    logic       accept;
    logic       load;
    logic       clear;
    logic       capture;
    logic       beat_fire;
    logic       beat_is_last;
    logic       commit;

    // Effective word length: 0 or oversize requests clamp to the full word.
    assign wle_d = (word_len == 4'd0 || word_len > BPW4) ? BPW4 : word_len;

    assign accept       = (state_q == ST_IDLE) && start && (mode == MODE_P2S || mode == MODE_S2P);
    assign load         = accept && (mode == MODE_P2S);
    assign clear        = accept && (mode == MODE_S2P);
    assign capture      = (state_q == ST_RUN) && (mode_q == MODE_S2P) && s_in_valid;
    assign beat_fire    = (s_out_valid && s_out_ready) || capture;
    assign beat_is_last = (beat_q == beat_last_q);
    assign commit       = capture && beat_is_last;

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_IDLE;
            beat_q      <= '0;
            beat_last_q <= '0;
            word_q      <= '0;
            byte_q      <= '0;
            byte_last_q <= '0;
            busy        <= 1'b0;
            finish      <= 1'b0;
            s_out_valid <= 1'b0;
            s_in_ready  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    finish <= 1'b0;
                    if (accept) begin
                        state_q     <= ST_RUN;
                        mode_q      <= psc_mode_e'(mode);
                        beat_q      <= '0;
                        word_q      <= '0;
                        byte_q      <= '0;
                        byte_last_q <= BIDX_W'(wle_d - 4'd1);
                        beat_last_q <= BEAT_W'(WORDS_PER_LANE * int'(wle_d) - 1);
                        busy        <= 1'b1;
                        s_out_valid <= (mode == MODE_P2S);
                        s_in_ready  <= (mode == MODE_S2P);
                    end
                end
                ST_RUN: begin
                    if (beat_fire) begin
                        if (beat_is_last) begin
                            state_q     <= ST_DONE;
                            finish      <= 1'b1;
                            s_out_valid <= 1'b0;
                            s_in_ready  <= 1'b0;
                            beat_q      <= '0;
                            word_q      <= '0;
                            byte_q      <= '0;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                            if (byte_q == byte_last_q) begin
                                byte_q <= '0;
                                word_q <= word_q + WIDX_W'(1);
                            end else begin
                                byte_q <= byte_q + BIDX_W'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    finish  <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                    finish  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < L; i++) begin : g_lane
        psc_lane #(
            .MAX_WORD_LENGTH (MAX_WORD_LENGTH),
            .WORDS_PER_LANE  (WORDS_PER_LANE),
            .WIDX_W          (WIDX_W),
            .BIDX_W          (BIDX_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .clear    (clear),
            .capture  (capture),
            .commit   (commit),
            .ser_en   (s_out_valid),
            .word_idx (word_q),
            .byte_idx (byte_q),
            .par_in   (parallel_data_in[i*LANE_W +: LANE_W]),
            .ser_in   (serial_data_in[i*BYTE_W +: BYTE_W]),
            .ser_out  (serial_data_out[i*BYTE_W +: BYTE_W]),
            .par_out  (parallel_data_out[i*LANE_W +: LANE_W])
        );
    end

`ifdef PSC_STREAM_ARRAY_STATS_EN
    // Saturating count of completed transfers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_count <= '0;
        end else if (finish && xfer_count != 16'hFFFF) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`else
    // Statistics disabled: no transfer counter is built.
`endif

endmodule

// File: tb/tb_psc_stream_array.sv
// Self-checking bench for psc_stream_array (default parameters, L=4).
// Table-driven transfers plus hand-written reset-abort and statistics sequences.
module tb_psc_stream_array;

    localparam int MAXW = 16;
    localparam int WPL  = 4;
    localparam int L    = 4;
    localparam int PW   = WPL * MAXW * L;
    localparam int SW   = 8 * L;

    logic          clk;
    logic          reset;
    logic [1:0]    mode;
    logic [3:0]    word_len;
    logic          start;
    logic          busy;
    logic          finish;
    logic [SW-1:0] serial_data_in;
    logic          s_in_valid;
    logic          s_in_ready;
    logic [SW-1:0] serial_data_out;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [PW-1:0] parallel_data_in;
    logic [PW-1:0] parallel_data_out;
`ifdef PSC_STREAM_ARRAY_STATS_EN
    logic [15:0]   xfer_count;
`endif

    psc_stream_array #(
        .MAX_WORD_LENGTH (16),
        .ARRAY_DIM       (2),
        .TILE_DIM        (2),
        .WORDS_PER_LANE  (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mode              (mode),
        .word_len          (word_len),
        .start             (start),
        .busy              (busy),
        .finish            (finish),
        .serial_data_in    (serial_data_in),
        .s_in_valid        (s_in_valid),
        .s_in_ready        (s_in_ready),
        .serial_data_out   (serial_data_out),
        .s_out_valid       (s_out_valid),
        .s_out_ready       (s_out_ready),
        .parallel_data_in  (parallel_data_in),
        .parallel_data_out (parallel_data_out)
`ifdef PSC_STREAM_ARRAY_STATS_EN
        ,
        .xfer_count        (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] word_len;
        bit         stall;
        logic [7:0] base;
        logic [7:0] stride;
        int         exp_beats;
    } vec_t;

    vec_t          vecs [11];
    int            n_tests;
    int            n_fail;
    logic [PW-1:0] pdo_model;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] s2p_byte(input vec_t v, input int k, input int ln);
        return 8'(int'(v.base) + k + ln * int'(v.stride));
    endfunction

    function automatic logic [SW-1:0] exp_ser(input logic [PW-1:0] p, input int k, input int wle);
        logic [SW-1:0] r;
        int w;
        int b;
        w = k / wle;
        b = k % wle;
        r = '0;
        for (int ln = 0; ln < L; ln++) r[ln*8 +: 8] = p[(ln*WPL + w)*MAXW + b*8 +: 8];
        return r;
    endfunction

    function automatic logic [PW-1:0] make_pdi(input int seed);
        logic [PW-1:0] p;
        for (int j = 0; j < WPL*L; j++) p[j*MAXW +: MAXW] = 16'(j*32'h1357 + seed*32'h00F1 + 32'h2468);
        return p;
    endfunction

    task automatic run_vec(input int i);
        vec_t          v;
        logic [PW-1:0] pdi;
        logic [PW-1:0] exp_pdo;
        int            wle;
        int            beats;
        int            fin_cyc;
        int            last_acc;
        int            budget;
        bit            active;
        v       = vecs[i];
        wle     = (v.word_len == 4'd0 || v.word_len > 4'd2) ? 2 : int'(v.word_len);
        active  = (v.mode == 2'b01 || v.mode == 2'b10);
        budget  = active ? 40 : 10;
        pdi     = make_pdi(i);
        exp_pdo = pdo_model;
        if (v.mode == 2'b10) begin
            exp_pdo = '0;
            for (int k = 0; k < WPL*wle; k++)
                for (int ln = 0; ln < L; ln++)
                    exp_pdo[(ln*WPL + k/wle)*MAXW + (k%wle)*8 +: 8] = s2p_byte(v, k, ln);
        end
        beats = 0; fin_cyc = 0; last_acc = 0;

        @(posedge clk); #1;
        mode = v.mode; word_len = v.word_len; start = 1'b1; parallel_data_in = pdi;
        s_out_ready = 1'b0; s_in_valid = 1'b0;
        @(posedge clk); #1;
        // Changes after the accepting edge must have no effect.
        start = 1'b0; mode = 2'b00; word_len = 4'd1; parallel_data_in = ~pdi;

        for (int cyc = 1; cyc <= budget; cyc++) begin
            s_out_ready = v.stall ? cyc[0] : 1'b1;
            s_in_valid  = v.stall ? cyc[0] : 1'b1;
            for (int ln = 0; ln < L; ln++)
                serial_data_in[ln*8 +: 8] = s_in_valid ? s2p_byte(v, beats, ln) : 8'hEE;
            @(negedge clk);
            if (finish) begin
                fin_cyc = cyc;
                break;
            end
            check($sformatf("v%0d_busy", i), PW'(busy), PW'(active));
            check($sformatf("v%0d_s_out_valid", i), PW'(s_out_valid), PW'(v.mode == 2'b01));
            check($sformatf("v%0d_s_in_ready", i), PW'(s_in_ready), PW'(v.mode == 2'b10));
            check($sformatf("v%0d_pdo_hold", i), parallel_data_out, pdo_model);
            if (s_out_valid) begin
                check($sformatf("v%0d_byte%0d", i, beats), PW'(serial_data_out), PW'(exp_ser(pdi, beats, wle)));
                if (s_out_ready) begin
                    beats++;
                    last_acc = cyc;
                end
            end else begin
                check($sformatf("v%0d_sdo_zero", i), PW'(serial_data_out), '0);
                if (s_in_ready && s_in_valid) begin
                    beats++;
                    last_acc = cyc;
                end
            end
            @(posedge clk); #1;
        end
        s_out_ready = 1'b0;
        s_in_valid  = 1'b0;

        check($sformatf("v%0d_beats", i), PW'(beats), PW'(v.exp_beats));
        if (active) begin
            check($sformatf("v%0d_finish_seen", i), PW'(fin_cyc != 0), PW'(1));
            check($sformatf("v%0d_finish_lat", i), PW'(fin_cyc), PW'(last_acc + 1));
            if (!v.stall) check($sformatf("v%0d_finish_at", i), PW'(fin_cyc), PW'(v.exp_beats + 1));
            check($sformatf("v%0d_busy_done", i), PW'(busy), PW'(1));
            check($sformatf("v%0d_pdo_done", i), parallel_data_out, exp_pdo);
            pdo_model = exp_pdo;
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("v%0d_finish_pulse", i), PW'(finish), '0);
            check($sformatf("v%0d_busy_idle", i), PW'(busy), '0);
        end else begin
            check($sformatf("v%0d_noop_finish", i), PW'(fin_cyc), '0);
        end
    endtask

    // Start a P2S transfer, let beats_before beats complete, then pull reset low.
    task automatic abort_p2s(input int beats_before);
        @(posedge clk); #1;
        mode = 2'b01; word_len = 4'd2; start = 1'b1; parallel_data_in = make_pdi(20);
        @(posedge clk); #1;
        start = 1'b0; mode = 2'b00; s_out_ready = 1'b1;
        repeat (beats_before) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_busy", PW'(busy), '0);
        check("abort_finish", PW'(finish), '0);
        check("abort_s_out_valid", PW'(s_out_valid), '0);
        check("abort_s_in_ready", PW'(s_in_ready), '0);
        check("abort_sdo", PW'(serial_data_out), '0);
        check("abort_pdo", parallel_data_out, '0);
        pdo_model = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_finish_rst", PW'(finish), '0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        s_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_finish", PW'(finish | busy), '0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pdo_model = '0;
        //          mode   wl     stall base   stride beats
        vecs[0]  = '{2'b01, 4'd2, 1'b0, 8'h00, 8'h00, 8};
        vecs[1]  = '{2'b01, 4'd2, 1'b1, 8'h00, 8'h00, 8};
        vecs[2]  = '{2'b10, 4'd1, 1'b0, 8'hA1, 8'h00, 4};
        vecs[3]  = '{2'b01, 4'd0, 1'b0, 8'h00, 8'h00, 8};
        vecs[4]  = '{2'b01, 4'd9, 1'b0, 8'h00, 8'h00, 8};
        vecs[5]  = '{2'b10, 4'd0, 1'b0, 8'h30, 8'h10, 8};
        vecs[6]  = '{2'b10, 4'd2, 1'b1, 8'h50, 8'h08, 8};
        vecs[7]  = '{2'b01, 4'd1, 1'b0, 8'h00, 8'h00, 4};
        vecs[8]  = '{2'b11, 4'd2, 1'b0, 8'h00, 8'h00, 0};
        vecs[9]  = '{2'b00, 4'd2, 1'b0, 8'h00, 8'h00, 0};
        vecs[10] = '{2'b10, 4'd3, 1'b0, 8'h11, 8'h20, 8};

        reset = 1'b1; mode = 2'b00; word_len = 4'd0; start = 1'b0;
        serial_data_in = '0; s_in_valid = 1'b0; s_out_ready = 1'b0; parallel_data_in = '0;
        #2 reset = 1'b0;
        #2;
        check("rst_busy", PW'(busy), '0);
        check("rst_finish", PW'(finish), '0);
        check("rst_s_out_valid", PW'(s_out_valid), '0);
        check("rst_s_in_ready", PW'(s_in_ready), '0);
        check("rst_sdo", PW'(serial_data_out), '0);
        check("rst_pdo", parallel_data_out, '0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i);

        // Reset after the third beat, then the full transfer must still run.
        abort_p2s(3);
        run_vec(0);

`ifdef PSC_STREAM_ARRAY_STATS_EN
        abort_p2s(2);
        check("stats_after_abort", PW'(xfer_count), '0);
        run_vec(0);
        run_vec(2);
        run_vec(7);
        repeat (3) @(negedge clk);
        check("stats_count", PW'(xfer_count), PW'(3));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
